// File: rtl/bc_auto_guesser.sv
// Bulls-and-Cows codebreaker: presents the smallest 4-distinct-digit BCD candidate that is
// consistent with all feedback so far. Optional macro BC_GUESSER_STATS_EN adds scan_cycles.
module bc_auto_guesser #(
    parameter int MAX_TRIES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        fb_valid,
    input  logic [3:0]  strike,
    input  logic [3:0]  ball,
    output logic [15:0] guess,
    output logic        guess_valid,
    output logic        busy,
    output logic        solved,
    output logic        fail,
    output logic [3:0]  try_count
`ifdef BC_GUESSER_STATS_EN
    ,
    output logic [15:0] scan_cycles
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_CHECK,
        ST_PRESENT,
        ST_SOLVED,
        ST_FAIL
    } state_t;

    localparam logic [3:0] MAX_T = 4'(MAX_TRIES);

    state_t      state_q, state_d;
    logic [15:0] cand_q, cand_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  hist_cnt_q, hist_cnt_d;
    logic [15:0] guess_q, guess_d;
    logic [3:0]  try_q, try_d;
    logic        guess_valid_q, busy_q, solved_q, fail_q;
    logic        hist_we;

    // Sized to the full 4-bit index range so history pointers never need narrowing.
    logic [15:0] hist_guess [16];
    logic [3:0]  hist_s     [16];
    logic [3:0]  hist_b     [16];

    logic [16:0] cand_inc;
    logic [7:0]  cand_score;
    logic        hist_hit;
    logic [4:0]  fb_sum;

    function automatic logic [16:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        logic [3:0]  n;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n = v[i*4 +: 4];
            if (c) begin
                if (n == 4'd9) begin
                    n = 4'd0;
                end else begin
                    n = n + 4'd1;
                    c = 1'b0;
                end
            end
            r[i*4 +: 4] = n;
        end
        return {c, r};
    endfunction

    function automatic logic distinct(input logic [15:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (v[i*4 +: 4] == v[j*4 +: 4]) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [7:0] score(input logic [15:0] a, input logic [15:0] h);
        logic [3:0] s;
        logic [3:0] b;
        s = 4'd0;
        b = 4'd0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (a[i*4 +: 4] == h[j*4 +: 4]) begin
                    if (i == j) s = s + 4'd1;
                    else        b = b + 4'd1;
                end
        return {s, b};
    endfunction

    assign cand_inc   = bcd_inc(cand_q);
    assign cand_score = score(cand_q, hist_guess[idx_q]);
    assign hist_hit   = (cand_score == {hist_s[idx_q], hist_b[idx_q]});
    assign fb_sum     = {1'b0, strike} + {1'b0, ball};

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        idx_d      = idx_q;
        hist_cnt_d = hist_cnt_q;
        guess_d    = guess_q;
        try_d      = try_q;
        hist_we    = 1'b0;
        if (start) begin
            state_d    = ST_SCAN;
            cand_d     = 16'h0000;
            idx_d      = 4'd0;
            hist_cnt_d = 4'd0;
            try_d      = 4'd0;
        end else begin
            case (state_q)
                ST_SCAN: begin
                    if (!distinct(cand_q)) begin
                        if (cand_inc[16]) state_d = ST_FAIL;
                        else              cand_d  = cand_inc[15:0];
                    end else if (hist_cnt_q == 4'd0) begin
                        state_d = ST_PRESENT;
                        guess_d = cand_q;
                        try_d   = try_q + 4'd1;
                    end else begin
                        state_d = ST_CHECK;
                        idx_d   = 4'd0;
                    end
                end
                ST_CHECK: begin
                    if (!hist_hit) begin
                        if (cand_inc[16]) begin
                            state_d = ST_FAIL;
                        end else begin
                            cand_d  = cand_inc[15:0];
                            state_d = ST_SCAN;
                        end
                    end else if (idx_q == hist_cnt_q - 4'd1) begin
                        state_d = ST_PRESENT;
                        guess_d = cand_q;
                        try_d   = try_q + 4'd1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
                ST_PRESENT: begin
                    if (fb_valid) begin
                        if (fb_sum > 5'd4 || (strike == 4'd3 && ball == 4'd1)) begin
                            state_d = ST_FAIL;
                        end else if (strike == 4'd4) begin
                            state_d = ST_SOLVED;
                        end else begin
                            hist_we    = 1'b1;
                            hist_cnt_d = hist_cnt_q + 4'd1;
                            if (hist_cnt_q + 4'd1 == MAX_T) begin
                                state_d = ST_FAIL;
                            end else if (cand_inc[16]) begin
                                state_d = ST_FAIL;
                            end else begin
                                cand_d  = cand_inc[15:0];
                                state_d = ST_SCAN;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cand_q        <= 16'h0000;
            idx_q         <= 4'd0;
            hist_cnt_q    <= 4'd0;
            guess_q       <= 16'h0000;
            try_q         <= 4'd0;
            guess_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            solved_q      <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cand_q        <= cand_d;
            idx_q         <= idx_d;
            hist_cnt_q    <= hist_cnt_d;
            guess_q       <= guess_d;
            try_q         <= try_d;
            guess_valid_q <= (state_d == ST_PRESENT);
            busy_q        <= (state_d == ST_SCAN) || (state_d == ST_CHECK);
            solved_q      <= (state_d == ST_SOLVED);
            fail_q        <= (state_d == ST_FAIL);
            if (hist_we) begin
                hist_guess[hist_cnt_q] <= guess_q;
                hist_s[hist_cnt_q]     <= strike;
                hist_b[hist_cnt_q]     <= ball;
            end
        end
    end

    assign guess       = guess_q;
    assign guess_valid = guess_valid_q;
    assign busy        = busy_q;
    assign solved      = solved_q;
    assign fail        = fail_q;
    assign try_count   = try_q;

`ifdef BC_GUESSER_STATS_EN
    logic [15:0] scan_cycles_q;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            scan_cycles_q <= 16'h0000;
        end else if ((state_q == ST_SCAN || state_q == ST_CHECK) && scan_cycles_q != 16'hFFFF) begin
            scan_cycles_q <= scan_cycles_q + 16'd1;
        end
    end

    assign scan_cycles = scan_cycles_q;
`endif

endmodule

// File: tb/tb_bc_auto_guesser.sv
// Scoreboard bench for bc_auto_guesser: two instances (MAX_TRIES=8 and MAX_TRIES=2).
module tb_bc_auto_guesser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start0, fbv0, start1, fbv1;
    logic [3:0]  str0, bal0, str1, bal1;
    logic [15:0] g0, g1;
    logic        gv0, gv1, busy0, busy1, sol0, sol1, fl0, fl1;
    logic [3:0]  tc0, tc1;
`ifdef BC_GUESSER_STATS_EN
    logic [15:0] sc0, sc1;
`endif

    bc_auto_guesser #(.MAX_TRIES(8)) u0 (
        .clk(clk), .rst(rst), .start(start0), .fb_valid(fbv0), .strike(str0), .ball(bal0),
        .guess(g0), .guess_valid(gv0), .busy(busy0), .solved(sol0), .fail(fl0),
        .try_count(tc0)
`ifdef BC_GUESSER_STATS_EN
        , .scan_cycles(sc0)
`endif
    );

    bc_auto_guesser #(.MAX_TRIES(2)) u1 (
        .clk(clk), .rst(rst), .start(start1), .fb_valid(fbv1), .strike(str1), .ball(bal1),
        .guess(g1), .guess_valid(gv1), .busy(busy1), .solved(sol1), .fail(fl1),
        .try_count(tc1)
`ifdef BC_GUESSER_STATS_EN
        , .scan_cycles(sc1)
`endif
    );

    // kind: 0 = new guess presented, 1 = solved, 2 = fail
    typedef struct {
        int          kind;
        logic [15:0] g;
        logic [3:0]  tc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   failures = 0;
    logic prev_gv[2], prev_sol[2], prev_fl[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(input int u, input int kind, input logic [15:0] g, input logic [3:0] tc);
        exp_t e;
        e.kind = kind;
        e.g    = g;
        e.tc   = tc;
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic handle_event(input int u, input int kind, input logic [15:0] g, input logic [3:0] tc);
        exp_t e;
        int   n;
        n = (u == 0) ? q0.size() : q1.size();
        if (n == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event u%0d: got kind=%0d guess=%h try=%0d expected none",
                     u, kind, g, tc);
        end else begin
            if (u == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            check($sformatf("event_kind_u%0d", u), kind, e.kind);
            check($sformatf("event_guess_u%0d", u), {16'h0, g}, {16'h0, e.g});
            check($sformatf("event_try_u%0d", u), {28'h0, tc}, {28'h0, e.tc});
            $display("u%0d event kind=%0d guess=%h try=%0d", u, kind, g, tc);
        end
    endtask

    task automatic mon(input int u, input logic gv, input logic sol, input logic fl,
                       input logic [15:0] g, input logic [3:0] tc);
        if (gv && !prev_gv[u])   handle_event(u, 0, g, tc);
        if (sol && !prev_sol[u]) handle_event(u, 1, g, tc);
        if (fl && !prev_fl[u])   handle_event(u, 2, g, tc);
        prev_gv[u]  = gv;
        prev_sol[u] = sol;
        prev_fl[u]  = fl;
    endtask

    always @(negedge clk) mon(0, gv0, sol0, fl0, g0, tc0);
    always @(negedge clk) mon(1, gv1, sol1, fl1, g1, tc1);

    task automatic do_start(input int u);
        @(posedge clk); #1;
        if (u == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic pulse_fb(input int u, input logic [3:0] s, input logic [3:0] b);
        @(posedge clk); #1;
        if (u == 0) begin fbv0 = 1'b1; str0 = s; bal0 = b; end
        else        begin fbv1 = 1'b1; str1 = s; bal1 = b; end
        @(posedge clk); #1;
        fbv0 = 1'b0;
        fbv1 = 1'b0;
    endtask

    task automatic drain(input int u, input int limit, input string name);
        int n;
        n = 1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk); #1;
            n = (u == 0) ? q0.size() : q1.size();
            if (n == 0) break;
        end
        if (n != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout_%s: got %0d pending events expected 0 within %0d cycles",
                     name, n, limit);
            if (u == 0) q0.delete(); else q1.delete();
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            prev_gv[i] = 1'b0; prev_sol[i] = 1'b0; prev_fl[i] = 1'b0;
        end
        rst = 1'b1;
        start0 = 1'b0; fbv0 = 1'b0; str0 = 4'd0; bal0 = 4'd0;
        start1 = 1'b0; fbv1 = 1'b0; str1 = 4'd0; bal1 = 4'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_guess", {16'h0, g0}, 32'h0);
        check("reset_guess_valid", {31'h0, gv0}, 32'h0);
        check("reset_busy", {31'h0, busy0}, 32'h0);
        check("reset_solved", {31'h0, sol0}, 32'h0);
        check("reset_fail", {31'h0, fl0}, 32'h0);
        check("reset_try", {28'h0, tc0}, 32'h0);

        // Feedback while idle must be ignored
        pulse_fb(0, 4'd4, 4'd0);
        repeat (2) @(negedge clk);
        check("idle_fb_solved", {31'h0, sol0}, 32'h0);
        check("idle_fb_busy", {31'h0, busy0}, 32'h0);
        check("idle_fb_try", {28'h0, tc0}, 32'h0);

        // Game 1: 0/3 then solved on 1034
        push(0, 0, 16'h0123, 4'd1);
        do_start(0);
        @(negedge clk);
        check("start_busy", {31'h0, busy0}, 32'h1);
        drain(0, 130, "first_guess");
        push(0, 0, 16'h1034, 4'd2);
        pulse_fb(0, 4'd0, 4'd3);
        drain(0, 5000, "guess_1034");
        push(0, 1, 16'h1034, 4'd2);
        pulse_fb(0, 4'd4, 4'd0);
        drain(0, 5, "solved");
        check("solved_guess_held", {16'h0, g0}, 32'h1034);
        check("solved_guess_valid", {31'h0, gv0}, 32'h0);
        check("solved_busy", {31'h0, busy0}, 32'h0);

        // Game 2: two 0/0 answers leave only digits 8/9, search space exhausts
        push(0, 0, 16'h0123, 4'd1);
        do_start(0);
        check("restart_solved_cleared", {31'h0, sol0}, 32'h0);
        drain(0, 130, "g2_first");
        push(0, 0, 16'h4567, 4'd2);
        pulse_fb(0, 4'd0, 4'd0);
        drain(0, 20000, "guess_4567");
        push(0, 2, 16'h4567, 4'd2);
        pulse_fb(0, 4'd0, 4'd0);
        drain(0, 60000, "exhaust");
        check("exhaust_fail", {31'h0, fl0}, 32'h1);
        check("exhaust_guess_valid", {31'h0, gv0}, 32'h0);

        // Game 3: illegal feedback 3/2 fails at once
        push(0, 0, 16'h0123, 4'd1);
        do_start(0);
        check("restart_fail_cleared", {31'h0, fl0}, 32'h0);
        drain(0, 130, "g3_first");
        push(0, 2, 16'h0123, 4'd1);
        pulse_fb(0, 4'd3, 4'd2);
        drain(0, 2, "illegal_fb");
        check("illegal_fb_busy", {31'h0, busy0}, 32'h0);

        // MAX_TRIES=2 instance: history fills after two feedbacks
        push(1, 0, 16'h0123, 4'd1);
        do_start(1);
        drain(1, 130, "u1_first");
        push(1, 0, 16'h1456, 4'd2);
        pulse_fb(1, 4'd0, 4'd1);
        drain(1, 5000, "u1_second");
        push(1, 2, 16'h1456, 4'd2);
        pulse_fb(1, 4'd0, 4'd1);
        drain(1, 5, "u1_tries");

        // Restart (with a colliding fb_valid) while checking the third candidate
        push(0, 0, 16'h0123, 4'd1);
        do_start(0);
        drain(0, 130, "g4_first");
        push(0, 0, 16'h1034, 4'd2);
        pulse_fb(0, 4'd0, 4'd3);
        drain(0, 5000, "g4_1034");
        @(posedge clk); #1;
        fbv0 = 1'b1; str0 = 4'd0; bal0 = 4'd2;
        @(posedge clk); #1;
        fbv0 = 1'b0;
        @(posedge clk); #1;
        push(0, 0, 16'h0123, 4'd1);
        start0 = 1'b1; fbv0 = 1'b1; str0 = 4'd4; bal0 = 4'd0;
        @(posedge clk); #1;
        start0 = 1'b0; fbv0 = 1'b0;
        @(negedge clk);
        check("restart_mid_busy", {31'h0, busy0}, 32'h1);
        check("restart_mid_try", {28'h0, tc0}, 32'h0);
        drain(0, 130, "restart_first");
        check("restart_final_try", {28'h0, tc0}, 32'h1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
